// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0 (SCLK idles low, MSB first), one byte per CS window.
// Host side: start/ready handshake, one-cycle done pulse, rx_data held until the next done.
// Optional feature macro: SPI_MASTER_BURST_EN -- when defined, a start seen in the last
// HOLD cycle chains the next byte without releasing CS.
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  // Counter widths are kept at least one bit so CLK_DIV=1 still elaborates.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // state | meaning
  // IDLE  | CS high, ready high, waiting for start
  // SETUP | CS low, SCLK low, first MOSI bit settling before the first rising edge
  // HIGH  | SCLK high half-period; slave samples MOSI
  // LOW   | SCLK low half-period between bits; MOSI already advanced
  // HOLD  | SCLK low after the last falling edge, CS still low
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t                state;
  logic [CNT_W-1:0]      half_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  last_half;

  assign last_half = (half_cnt == CNT_W'(CLK_DIV - 1));

  // Transfer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rx_data  <= '0;
      SCLK     <= 1'b0;
      CS       <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE)
        half_cnt <= last_half ? '0 : half_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start && ready) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            half_cnt <= '0;
            CS       <= 1'b0;
            ready    <= 1'b0;
            MOSI     <= tx_data[DATA_WIDTH-1];
            state    <= SETUP;
          end
        end

        SETUP, LOW: begin
          if (last_half) begin
            SCLK     <= 1'b1;
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
            state    <= HIGH;
          end
        end

        HIGH: begin
          if (last_half) begin
            SCLK <= 1'b0;
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              tx_shift <= tx_shift << 1;
              MOSI     <= tx_shift[DATA_WIDTH-2];
              state    <= LOW;
            end
          end
        end

        HOLD: begin
          if (last_half) begin
            rx_data <= rx_shift;
            done    <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            if (start) begin
              // Chain the next byte: CS and ready stay low, done marks the byte boundary.
              tx_shift <= tx_data;
              bit_cnt  <= '0;
              MOSI     <= tx_data[DATA_WIDTH-1];
              state    <= SETUP;
            end else begin
              CS    <= 1'b1;
              ready <= 1'b1;
              MOSI  <= 1'b0;
              state <= IDLE;
            end
`else
            CS    <= 1'b1;
            ready <= 1'b1;
            MOSI  <= 1'b0;
            state <= IDLE;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1), each wired to a
// behavioural mode-0 slave that echoes its previously received byte on MISO.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start0, start1;
  logic [7:0] tx0, tx1;
  logic       ready0, ready1, done0, done1;
  logic [7:0] rx0, rx1;
  logic       sclk0, sclk1, cs0, cs1, mosi0, mosi1, miso0, miso1;

  int checks = 0;
  int passes = 0;

  spi_master #(.CLK_DIV(4), .DATA_WIDTH(8)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .tx_data(tx0),
    .ready(ready0), .done(done0), .rx_data(rx0),
    .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0)
  );

  spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
    .ready(ready1), .done(done1), .rx_data(rx1),
    .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
  );

  logic [1:0] sclk_w, cs_w, mosi_w, miso_w;
  assign sclk_w = {sclk1, sclk0};
  assign cs_w   = {cs1, cs0};
  assign mosi_w = {mosi1, mosi0};
  assign miso0  = miso_w[0];
  assign miso1  = miso_w[1];

  // Mode-0 slave: loads its byte on CS fall, samples MOSI on SCLK rise, shifts on SCLK fall.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slv
    logic [7:0] data = (gi == 0) ? 8'h5A : 8'h96;
    logic [7:0] rx = 8'h00;
    logic [7:0] sh = 8'h00;
    int         cnt = 0;
    bit         reload = 1'b0;
    logic       pcs = 1'b1;
    logic       psclk = 1'b0;
    assign miso_w[gi] = sh[7];

    // Single process per slave so no variable has two writers.
    always @(cs_w[gi], sclk_w[gi]) begin
      if (pcs === 1'b1 && cs_w[gi] === 1'b0) begin
        sh = data; cnt = 0; rx = 8'h00; reload = 1'b0;
      end else if (cs_w[gi] === 1'b0 && psclk === 1'b0 && sclk_w[gi] === 1'b1) begin
        rx = {rx[6:0], mosi_w[gi]};
        cnt++;
        if (cnt == 8) begin
          data = rx; cnt = 0; reload = 1'b1;
        end
      end else if (cs_w[gi] === 1'b0 && psclk === 1'b1 && sclk_w[gi] === 1'b0) begin
        if (reload) begin
          sh = data; reload = 1'b0;
        end else begin
          sh = sh << 1;
        end
      end
      pcs = cs_w[gi];
      psclk = sclk_w[gi];
    end
  end

  int rise0 = 0, fall0 = 0, csfall0 = 0, mosi_viol = 0, done_cnt0 = 0;
  logic pm = 1'b0, ps = 1'b0, pc = 1'b1;

  // SCLK edge and CS-fall counters for instance 0.
  always @(sclk0, cs0) begin
    if (cs0 === 1'b0 && ps === 1'b0 && sclk0 === 1'b1) rise0++;
    if (cs0 === 1'b0 && ps === 1'b1 && sclk0 === 1'b0) fall0++;
    if (pc === 1'b1 && cs0 === 1'b0) csfall0++;
    ps = sclk0;
    pc = cs0;
  end

  // MOSI may only move when SCLK falls, when CS toggles, or on a burst accept (done cycle).
  logic pm_s = 1'b0, psc_s = 1'b0, pcs_s = 1'b1;
  always @(posedge clk) begin
    #1;
    if (mosi0 !== pm_s && !(psc_s && !sclk0) && (pcs_s === cs0) && !done0) mosi_viol++;
    if (done0 === 1'b1) done_cnt0++;
    pm_s = mosi0; psc_s = sclk0; pcs_s = cs0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic dut_done(input int d);
    return d ? done1 : done0;
  endfunction

  function automatic logic dut_cs(input int d);
    return d ? cs1 : cs0;
  endfunction

  function automatic logic dut_ready(input int d);
    return d ? ready1 : ready0;
  endfunction

  task automatic set_in(input int d, input logic s, input logic [7:0] t);
    if (d == 1) begin start1 = s; tx1 = t; end
    else begin start0 = s; tx0 = t; end
  endtask

  // Counts clk edges until done, sampled 1 time unit after each edge; 400 means timed out.
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (dut_done(d)) break;
    end
  endtask

  // One transfer; tx_data is overwritten with tx_late 20 cycles after accept.
  task automatic xfer(input int d, input logic [7:0] tx, input bit hold,
                      input logic [7:0] tx_late, output int lat, output int cslow);
    for (int i = 0; i < 200 && !dut_ready(d); i++) begin
      @(posedge clk); #1;
    end
    set_in(d, 1'b1, tx);
    @(posedge clk); #1;
    if (!hold) set_in(d, 1'b0, tx);
    cslow = (dut_cs(d) == 1'b0) ? 1 : 0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 20) set_in(d, hold, tx_late);
      if (dut_done(d)) break;
      if (dut_cs(d) == 1'b0) cslow++;
    end
  endtask

  int lat, csl, r_base, f_base, c_base, d_base;

  initial begin
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; tx0 = 8'h00; tx1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready0, 1);
    chk("rst_done",  done0,  0);
    chk("rst_rx",    rx0,    0);
    chk("rst_sclk",  sclk0,  0);
    chk("rst_cs",    cs0,    1);
    chk("rst_mosi",  mosi0,  0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: 0xA5, slave starts with 0x5A.
    r_base = rise0; f_base = fall0;
    xfer(0, 8'hA5, 1'b0, 8'hFF, lat, csl);
    chk("t1_latency", lat, 68);
    chk("t1_cs_low",  csl, 68);
    chk("t1_rises",   rise0 - r_base, 8);
    chk("t1_falls",   fall0 - f_base, 8);
    chk("t1_slave",   g_slv[0].data, 8'hA5);
    chk("t1_rx",      rx0, 8'h5A);
    chk("t1_cs_end",  cs0, 1);
    chk("t1_ready",   ready0, 1);
    @(posedge clk); #1;
    chk("t1_done_w",  done0, 0);

    // Test 2: echo of previous byte.
    xfer(0, 8'h3C, 1'b0, 8'h00, lat, csl);
    chk("t2_latency", lat, 68);
    chk("t2_rx",      rx0, 8'hA5);
    chk("t2_slave",   g_slv[0].data, 8'h3C);

`ifndef SPI_MASTER_BURST_EN
    // Test 3: start held, tx_data changed mid-transfer.
    c_base = csfall0;
    xfer(0, 8'hC3, 1'b1, 8'h0F, lat, csl);
    chk("t3_latency", lat, 68);
    chk("t3_slave",   g_slv[0].data, 8'hC3);
    chk("t3_one_cs",  csfall0 - c_base, 1);
    chk("t3_cs_done", cs0, 1);
    @(posedge clk); #1;
    chk("t3_reaccept", cs0, 0);
    start0 = 1'b0;
    wait_done(0, lat);
    chk("t3_lat2",    lat, 68);
    chk("t3_slave2",  g_slv[0].data, 8'h0F);
    chk("t3_rx2",     rx0, 8'hC3);
`else
    // Test 6: burst of 0x11 then 0x22 under one CS window.
    c_base = csfall0;
    xfer(0, 8'h11, 1'b1, 8'h22, lat, csl);
    chk("t6_latency", lat, 68);
    chk("t6_cs_hold", cs0, 0);
    chk("t6_ready0",  ready0, 0);
    chk("t6_slave1",  g_slv[0].data, 8'h11);
    chk("t6_rx1",     rx0, 8'h3C);
    start0 = 1'b0;
    wait_done(0, lat);
    chk("t6_lat2",    lat, 68);
    chk("t6_slave2",  g_slv[0].data, 8'h22);
    chk("t6_rx2",     rx0, 8'h11);
    chk("t6_cs_end",  cs0, 1);
    chk("t6_one_cs",  csfall0 - c_base, 1);
`endif

    // Test 4: reset at clk 30 of a transfer of 0x77.
    for (int i = 0; i < 200 && !ready0; i++) begin
      @(posedge clk); #1;
    end
    start0 = 1'b1; tx0 = 8'h77;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("t4_pre_sclk", sclk0, 1);
    chk("t4_pre_mosi", mosi0, 1);
    d_base = done_cnt0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_cs",    cs0,    1);
    chk("t4_sclk",  sclk0,  0);
    chk("t4_mosi",  mosi0,  0);
    chk("t4_ready", ready0, 1);
    chk("t4_rx",    rx0,    0);
    chk("t4_done",  done0,  0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt0 - d_base, 0);

    // Test 5: CLK_DIV=1 instance, 0xFF then 0x00.
    xfer(1, 8'hFF, 1'b0, 8'h00, lat, csl);
    chk("t5_lat1",   lat, 17);
    chk("t5_cs1",    csl, 17);
    chk("t5_rx1",    rx1, 8'h96);
    xfer(1, 8'h00, 1'b0, 8'hAA, lat, csl);
    chk("t5_lat2",   lat, 17);
    chk("t5_rx2",    rx1, 8'hFF);
    chk("t5_slave",  g_slv[1].data, 8'h00);

    chk("mosi_timing", mosi_viol, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
